// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly address generator.
package ntt_pkg;

    // Default transform size: N = 2^DefLogN coefficients.
    localparam int unsigned DefLogN = 3;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    // Ceiling log2, never smaller than 1 so that derived widths stay legal.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ntt_bit_insert.sv
// Inserts a zero bit into k at bit position pos_i; bits at and above pos_i move up one place.
module ntt_bit_insert #(
    parameter int unsigned W  = 3,
    parameter int unsigned SW = 2
) (
    input  logic [W-1:0]  k_i,
    input  logic [SW-1:0] pos_i,
    output logic [W-1:0]  addr_o
);

    logic [W-1:0] mask;

    // Keep the low pos_i bits in place, shift the remainder up by one.
    always_comb begin
        mask   = (W'(1) << pos_i) - W'(1);
        addr_o = ((k_i & ~mask) << 1) | (k_i & mask);
    end

endmodule

// File: rtl/ntt_addr_gen.sv
// Radix-2 DIT NTT butterfly sequencer: emits (addr_a, addr_b, tw_idx) per accepted beat.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_N  = DefLogN,
    parameter int unsigned ADDR_W = LOG_N,
    parameter int unsigned STG_W  = clog2_min1(LOG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [LOG_N-2:0]  tw_idx,
    output logic [STG_W-1:0]  stage,
    output logic              stage_last,
    output logic              done
);

    localparam int unsigned      KW    = LOG_N - 1;
    localparam logic [KW-1:0]    KLast = '1;
    localparam logic [STG_W-1:0] SLast = STG_W'(LOG_N - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [STG_W-1:0]  s_q, s_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic [LOG_N-2:0]  tw_q;
    logic [STG_W-1:0]  stage_q;
    logic              last_q;

    logic [ADDR_W-1:0] k_ext, half, j, ins_a, tw_full;
    logic [31:0]       tw_sh;

    // Next-state: counters advance only on an accepted beat.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    k_d     = '0;
                    s_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (valid_q && out_ready) begin
                    if (k_q == KLast) begin
                        k_d = '0;
                        if (s_q == SLast) begin
                            state_d = StFin;
                            s_d     = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            s_d = s_q + STG_W'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Beat arithmetic from the next (k, s) so the outputs are registered with the counters.
    always_comb begin
        k_ext   = ADDR_W'(k_d);
        half    = ADDR_W'(1) << s_d;
        j       = k_ext & (half - ADDR_W'(1));
        tw_sh   = 32'(LOG_N - 1) - 32'(s_d);
        tw_full = j << tw_sh;
    end

    ntt_bit_insert #(
        .W  (ADDR_W),
        .SW (STG_W)
    ) u_bit_insert (
        .k_i    (k_ext),
        .pos_i  (s_d),
        .addr_o (ins_a)
    );

    // State and output registers; outputs are zeroed whenever no beat is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            s_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= valid_d ? ins_a : '0;
            addr_b_q <= valid_d ? (ins_a | half) : '0;
            tw_q     <= valid_d ? tw_full[LOG_N-2:0] : '0;
            stage_q  <= valid_d ? s_d : '0;
            last_q   <= valid_d && (k_d == KLast);
        end
    end

    assign busy       = busy_q;
    assign out_valid  = valid_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign tw_idx     = tw_q;
    assign stage      = stage_q;
    assign stage_last = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: instances at LOG_N = 3, 2 and 5 checked against a table and a model.
module tb_ntt_addr_gen;

    localparam int LN_TAB [3] = '{3, 2, 5};

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int last;
    } beat_t;

    logic clk;
    logic rst;
    logic start_s [3];
    logic ready_s [3];
    wire       busy_s  [3];
    wire       valid_s [3];
    wire       done_s  [3];
    wire       last_s  [3];
    wire [4:0] a_s     [3];
    wire [4:0] b_s     [3];
    wire [3:0] tw_s    [3];
    wire [2:0] st_s    [3];

    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_cnt [3] = '{0, 0, 0};
    int    exp_done [3] = '{0, 0, 0};
    beat_t vec [12];
    beat_t mdl [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LN = LN_TAB[g];
        localparam int unsigned SW = ntt_pkg::clog2_min1(LN);
        logic [LN-1:0] a, b;
        logic [LN-2:0] tw;
        logic [SW-1:0] st;

        ntt_addr_gen #(.LOG_N(LN)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_s[g]),
            .busy       (busy_s[g]),
            .out_valid  (valid_s[g]),
            .out_ready  (ready_s[g]),
            .addr_a     (a),
            .addr_b     (b),
            .tw_idx     (tw),
            .stage      (st),
            .stage_last (last_s[g]),
            .done       (done_s[g])
        );

        assign a_s[g]  = 5'(a);
        assign b_s[g]  = 5'(b);
        assign tw_s[g] = 4'(tw);
        assign st_s[g] = 3'(st);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen on each instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1) done_cnt[i]++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference sequence built from butterfly groups: each stage walks groups of span
    // 2*half, pairing a with a+half; twiddle exponent scales j by N/(2*half).
    task automatic build_model(input int ln);
        int n;
        int half;
        beat_t e;
        mdl.delete();
        n = 1 << ln;
        for (int s = 0; s < ln; s++) begin
            half = 1 << s;
            for (int base = 0; base < n; base += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    e.a    = base + j;
                    e.b    = base + j + half;
                    e.tw   = j * (n / (2 * half));
                    e.st   = s;
                    e.last = (base == n - 2 * half && j == half - 1) ? 1 : 0;
                    mdl.push_back(e);
                end
            end
        end
    endtask

    // One full transform on instance g.
    // mode 0: ready held high; 1: random ready with a 3-cycle stall on beat 5;
    // 2: ready high plus stray start pulses at beat 4 and during FIN.
    task automatic run(input int g, input int mode, input bit use_tab);
        int    beat;
        int    cyc;
        int    stall;
        int    nb;
        bit    hs;
        beat_t e;
        beat  = 0;
        cyc   = 0;
        stall = 0;
        build_model(LN_TAB[g]);
        nb = mdl.size();
        ready_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        chk("launch_busy", 64'(busy_s[g]), 1);
        while (beat < nb && cyc < 4000) begin
            e = use_tab ? vec[beat] : mdl[beat];
            chk("valid", 64'(valid_s[g]), 1);
            chk("busy", 64'(busy_s[g]), 1);
            chk("done_early", 64'(done_s[g]), 0);
            chk("addr_a", 64'(a_s[g]), 64'(e.a));
            chk("addr_b", 64'(b_s[g]), 64'(e.b));
            chk("tw_idx", 64'(tw_s[g]), 64'(e.tw));
            chk("stage", 64'(st_s[g]), 64'(e.st));
            chk("stage_last", 64'(last_s[g]), 64'(e.last));
            if (mode == 1) begin
                if (beat == 5 && stall < 3) begin
                    ready_s[g] = 1'b0;
                    stall++;
                end else if (beat == 5) begin
                    ready_s[g] = 1'b1;
                end else begin
                    ready_s[g] = 1'($urandom_range(0, 1));
                end
            end else begin
                ready_s[g] = 1'b1;
            end
            start_s[g] = (mode == 2 && beat == 4);
            hs = (valid_s[g] === 1'b1) && ready_s[g];
            @(negedge clk);
            cyc++;
            if (hs) beat++;
        end
        start_s[g] = 1'b0;
        ready_s[g] = 1'b1;
        if (beat < nb) chk("timeout_beats", 64'(beat), 64'(nb));
        chk("done", 64'(done_s[g]), 1);
        chk("busy_fin", 64'(busy_s[g]), 0);
        chk("valid_fin", 64'(valid_s[g]), 0);
        exp_done[g]++;
        if (mode == 2) begin
            start_s[g] = 1'b1;
            @(negedge clk);
            start_s[g] = 1'b0;
            chk("fin_done_single", 64'(done_s[g]), 0);
            chk("fin_start_valid", 64'(valid_s[g]), 0);
            @(negedge clk);
            chk("fin_start_ignored", 64'(valid_s[g]), 0);
            chk("fin_start_busy", 64'(busy_s[g]), 0);
        end
    endtask

    initial begin
        vec[0]  = '{0, 1, 0, 0, 0};
        vec[1]  = '{2, 3, 0, 0, 0};
        vec[2]  = '{4, 5, 0, 0, 0};
        vec[3]  = '{6, 7, 0, 0, 1};
        vec[4]  = '{0, 2, 0, 1, 0};
        vec[5]  = '{1, 3, 2, 1, 0};
        vec[6]  = '{4, 6, 0, 1, 0};
        vec[7]  = '{5, 7, 2, 1, 1};
        vec[8]  = '{0, 4, 0, 2, 0};
        vec[9]  = '{1, 5, 1, 2, 0};
        vec[10] = '{2, 6, 2, 2, 0};
        vec[11] = '{3, 7, 3, 2, 1};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            ready_s[i] = 1'b1;
        end

        // Idle after reset: nothing moves without start, even with out_ready high.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outputs",
                {56'd0, busy_s[0], valid_s[0], done_s[0], last_s[0], 4'd0}
                | 64'(a_s[0]) | 64'(b_s[0]) | 64'(tw_s[0]) | 64'(st_s[0]), 0);
        end

        // Full LOG_N=3 transform against the hand table.
        run(0, 0, 1'b1);
        @(negedge clk);
        chk("done_single", 64'(done_s[0]), 0);

        // Backpressure.
        run(0, 1, 1'b0);
        @(negedge clk);
        chk("bp_done_single", 64'(done_s[0]), 0);

        // Stray starts while busy and in FIN.
        run(0, 2, 1'b0);

        // Back-to-back transforms: the second starts one cycle after done.
        run(0, 0, 1'b0);
        run(0, 0, 1'b0);

        // Asynchronous reset mid-transform, at stage-1 beat 2.
        build_model(3);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_addr_a", 64'(a_s[0]), 64'(mdl[5].a));
        chk("pre_rst_addr_b", 64'(b_s[0]), 64'(mdl[5].b));
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(valid_s[0]), 0);
        chk("async_rst_busy", 64'(busy_s[0]), 0);
        chk("async_rst_addr_b", 64'(b_s[0]), 0);
        chk("async_rst_stage", 64'(st_s[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 64'(valid_s[0]), 0);
        run(0, 0, 1'b0);

        // Width sweep.
        run(1, 0, 1'b0);
        run(2, 0, 1'b0);
        run(2, 1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("done_count", 64'(done_cnt[i]), 64'(exp_done[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
